// File: rtl/mxn_scan_pkg.sv
// ============================================================================
// Module  : mxn_scan_pkg
// Brief   : Shared FSM state encoding and default sizing for the mxn_scan block
// Revision: 1.0
// ============================================================================
`default_nettype none

package mxn_scan_pkg;

    localparam int DEF_W = 8;
    localparam int DEF_N = 6;

    typedef enum logic [0:0] {
        ST_STATIC = 1'b0,
        ST_SCAN   = 1'b1
    } state_e;

endpackage

`default_nettype wire

// File: rtl/mxn_scan_if.sv
// ============================================================================
// Module  : mxn_scan_if
// Brief   : Control/data bundle between the scan mux and its user
// Revision: 1.0
// ============================================================================
`default_nettype none

interface mxn_scan_if
    import mxn_scan_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int N = DEF_N
);
    localparam int SW = $clog2(N);

    logic [N*W-1:0] a;
    logic [SW-1:0]  sel;
    logic           ld_sel;
    logic           scan_en;
    logic [SW-1:0]  scan_last;
    logic           hold;
    logic [W-1:0]   q;
    logic [SW-1:0]  q_ch;
    logic           q_vld;
    logic           wrap;
    logic           sel_err;

    modport master (
        output a, sel, ld_sel, scan_en, scan_last, hold,
        input  q, q_ch, q_vld, wrap, sel_err
    );

    modport slave (
        input  a, sel, ld_sel, scan_en, scan_last, hold,
        output q, q_ch, q_vld, wrap, sel_err
    );

endinterface

`default_nettype wire

// File: rtl/mxn_sel.sv
// ============================================================================
// Module  : mxn_sel
// Brief   : Combinational N:1 W-bit channel mux; an index >= N selects zero
// Revision: 1.0
// ============================================================================
`default_nettype none

module mxn_sel #(
    parameter int W  = 8,
    parameter int N  = 6,
    parameter int SW = $clog2(N)
) (
    input  wire logic [N*W-1:0] i_a,
    input  wire logic [SW-1:0]  i_idx,
    output logic      [W-1:0]   o_y
);

    always_comb begin
        o_y = '0;
        for (int k = 0; k < N; k++) begin
            if (i_idx == SW'(k)) begin
                o_y = i_a[k*W +: W];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mxn_scan.sv
// ============================================================================
// Module  : mxn_scan
// Brief   : Registered channel selector with static and auto-scan modes
// Revision: 1.0
// ============================================================================
`default_nettype none

module mxn_scan
    import mxn_scan_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int N = DEF_N
) (
    input  wire logic   sys_clk,
    input  wire logic   reset,
    mxn_scan_if.slave   bus
);

    localparam int            SW     = $clog2(N);
    localparam logic [SW:0]   c_N    = (SW+1)'(N);
    localparam logic [SW-1:0] c_LAST = SW'(N - 1);

    state_e        r_state;
    logic [SW-1:0] r_cur;
    logic [W-1:0]  r_q;
    logic [SW-1:0] r_q_ch;
    logic          r_q_vld;
    logic          r_wrap;
    logic          r_sel_err;

    logic [W-1:0]  w_mux;
    logic [SW-1:0] w_eff_last;
    logic          w_sel_ok;

    mxn_sel #(
        .W  (W),
        .N  (N),
        .SW (SW)
    ) u_sel (
        .i_a   (bus.a),
        .i_idx (r_cur),
        .o_y   (w_mux)
    );

    // An out-of-range ring end clamps to the highest real channel.
    assign w_eff_last = ({1'b0, bus.scan_last} < c_N) ? bus.scan_last : c_LAST;
    assign w_sel_ok   = ({1'b0, bus.sel} < c_N);

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_STATIC;
            r_cur     <= '0;
            r_q       <= '0;
            r_q_ch    <= '0;
            r_q_vld   <= 1'b0;
            r_wrap    <= 1'b0;
            r_sel_err <= 1'b0;
        end else if (bus.hold) begin
            r_wrap    <= 1'b0;
            r_sel_err <= 1'b0;
        end else begin
            r_state   <= bus.scan_en ? ST_SCAN : ST_STATIC;
            r_q       <= w_mux;
            r_q_ch    <= r_cur;
            r_q_vld   <= 1'b1;
            r_wrap    <= 1'b0;
            r_sel_err <= 1'b0;
            if (bus.ld_sel) begin
                if (w_sel_ok) begin
                    r_cur <= bus.sel;
                end else begin
                    r_cur     <= '0;
                    r_sel_err <= 1'b1;
                end
            end else if (r_state == ST_SCAN) begin
                // ">=" also catches a cur left above a freshly lowered ring end.
                if (r_cur >= w_eff_last) begin
                    r_cur  <= '0;
                    r_wrap <= 1'b1;
                end else begin
                    r_cur <= r_cur + SW'(1);
                end
            end
        end
    end

    assign bus.q       = r_q;
    assign bus.q_ch    = r_q_ch;
    assign bus.q_vld   = r_q_vld;
    assign bus.wrap    = r_wrap;
    assign bus.sel_err = r_sel_err;

endmodule

`default_nettype wire

// File: doc/mxn_scan.md
MXN_SCAN -- requirements
Module: mxn_scan

Interface
REQ-001 Parameter W, default 8, data width per channel in bits.
REQ-002 Parameter N, default 6, channel count; legal range 2..16.
REQ-003 Parameter SW, default clog2(N), select width; derived, not overridden.
REQ-004 sys_clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 a  in  N*W  channel data; channel k occupies bits k*W+W-1..k*W.
REQ-007 sel  in  SW  channel index to load.
REQ-008 ld_sel  in  1  load sel into the select register.
REQ-009 scan_en  in  1  1 = SCAN mode (auto-step), 0 = STATIC mode.
REQ-010 scan_last  in  SW  last channel of the scan ring.
REQ-011 hold  in  1  freeze all state.
REQ-012 q  out  W  registered selected data.
REQ-013 q_ch  out  SW  channel index that q was sampled from.
REQ-014 q_vld  out  1  q holds a sample taken since reset.
REQ-015 wrap  out  1  one-cycle pulse when scan wraps to channel 0.
REQ-016 sel_err  out  1  one-cycle pulse when an out-of-range sel is loaded.

Function
REQ-017 The block SHALL hold a select register cur (SW bits) and a two-state FSM: STATIC, SCAN.
REQ-018 FSM SHALL move STATIC->SCAN when scan_en=1 and SCAN->STATIC when scan_en=0, evaluated each non-held cycle.
REQ-019 Each non-held cycle: q<=a[cur], q_ch<=cur, q_vld<=1; latency one cycle from cur to q.
REQ-020 Priority per cycle SHALL be: reset > hold > ld_sel > scan step.
REQ-021 hold=1: cur, FSM, q, q_ch, q_vld unchanged; wrap and sel_err SHALL be 0.
REQ-022 ld_sel=1 with sel<N: cur<=sel; no scan step that cycle.
REQ-023 ld_sel=1 with sel>=N: cur<=0, sel_err=1 next cycle.
REQ-024 In SCAN, no ld_sel: cur<=cur+1, except cur>=eff_last gives cur<=0 and wrap=1 next cycle.
REQ-025 eff_last = scan_last if scan_last<N, else N-1.
REQ-026 In STATIC, no ld_sel: cur unchanged.
REQ-027 Change of scan_last mid-scan SHALL take effect on the next step comparison; cur above new eff_last wraps to 0 on next step.
REQ-028 q SHALL reflect the a value present at the sampling edge; no combinational path from a or sel to any output.

Reset
REQ-029 reset SHALL asynchronously force: cur=0, FSM=STATIC, q=0, q_ch=0, q_vld=0, wrap=0, sel_err=0.
REQ-030 Deassertion mid-scan SHALL restart from channel 0; first q_vld=1 on the first non-held edge after reset release.

Structure
REQ-031 Shared package SHALL hold the FSM state enum (ST_STATIC, ST_SCAN) and the default W/N constants.
REQ-032 One sub-module, mxn_sel (combinational parametrised N:1 W-bit mux, index>=N yields 0), SHALL be instantiated for the data path.
REQ-033 Remaining logic (select register, FSM, output registers) SHALL live in mxn_scan; target 120-400 RTL lines.

Verification (W=8, N=6)
REQ-034 a={0x66,0x55,0x44,0x33,0x22,0x11} (ch5..ch0), ld_sel=1 sel=3 one cycle -> two edges later q=0x44, q_ch=3, q_vld=1.
REQ-035 scan_en=1, scan_last=5, from cur=0 -> q_ch sequence 0,1,2,3,4,5,0; wrap=1 exactly in the cycle cur returns to 0.
REQ-036 scan_last=7 (out of range) -> ring 0..5 identical to REQ-035; scan_last=2 -> ring 0,1,2,0.
REQ-037 ld_sel=1 sel=6 -> cur=0, sel_err pulses 1 cycle; same cycle hold=1 -> no change, sel_err=0.
REQ-038 SCAN at cur=4, ld_sel=1 sel=1 and scan step same cycle -> cur=1 (load wins), next step 2.
REQ-039 reset asserted asynchronously mid-scan at cur=3 -> all outputs 0 immediately; after release scan resumes at 0.
